battle_engine: RTL and testbench

Turn-based battle controller that runs while the top-level game FSM sits in its Battle state. It owns both sides' HP, the active-monster indices and the enemy team. It turns raw keyboard codes into move selections and returns `end_battle`/`result` to the game FSM. It also supplies `my_cur` and `enemy_cur_id`, which drive the battle sprite lookups.

---
 rtl/battle_engine_if.sv | 27 ++
 rtl/battle_engine.sv | 163 ++++++++++++++++
 tb/tb_battle_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/battle_engine_if.sv
// Signal bundle between the game FSM (master) and the battle engine (slave).
// Clock and reset stay as plain ports on the modules that use this bundle.
interface battle_engine_if;
    logic            start_battle;
    logic [7:0]      keycode;
    logic [2:0][2:0] my_team;
    logic            end_battle;
    logic            result;
    logic [1:0]      my_cur;
    logic [2:0]      enemy_cur_id;
    logic [7:0]      my_hp;
    logic [7:0]      enemy_hp;
    logic [1:0]      move_sel;
    logic            busy;

    modport master (
        output start_battle, keycode, my_team,
        input  end_battle, result, my_cur, enemy_cur_id,
               my_hp, enemy_hp, move_sel, busy
    );

    modport slave (
        input  start_battle, keycode, my_team,
        output end_battle, result, my_cur, enemy_cur_id,
               my_hp, enemy_hp, move_sel, busy
    );
endinterface

// File: rtl/battle_engine.sv
// Turn-based battle controller: owns both sides' HP, active indices and the
// enemy team, decodes key presses into moves and reports the outcome.
module battle_engine #(
    parameter logic [7:0]  MAX_HP      = 8'd100,
    parameter logic [7:0]  DMG0        = 8'd20,
    parameter logic [7:0]  DMG1        = 8'd15,
    parameter logic [7:0]  DMG2        = 8'd30,
    parameter logic [7:0]  DMG3        = 8'd10,
    parameter logic [7:0]  ENEMY_DMG   = 8'd12,
    parameter logic [24:0] WAIT_CYCLES = 25'd25_000_000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input logic             Clk,
    input logic             Reset,
    battle_engine_if.slave  bus
);
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_SEL, S_PHIT, S_ECHK, S_EHIT, S_PCHK, S_WAIT, S_DONE
    } state_t;

    state_t          state, ret_state;
    logic [7:0]      lfsr;
    logic [7:0]      prev_key;
    logic [2:0][2:0] enemy_ids;
    logic [1:0]      enemy_idx;
    logic [1:0]      my_cur;
    logic [7:0]      my_hp, enemy_hp;
    logic [1:0]      move_sel;
    logic            result, end_battle, busy;
    logic [24:0]     wait_cnt;

    logic            key_press;
    logic [7:0]      player_dmg;
    logic [8:0]      enemy_dmg;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        player_dmg = DMG0;
        case (move_sel)
            2'd1:    player_dmg = DMG1;
            2'd2:    player_dmg = DMG2;
            2'd3:    player_dmg = DMG3;
            default: player_dmg = DMG0;
        endcase
        enemy_dmg = {1'b0, ENEMY_DMG} + {6'd0, lfsr[2:0]};
        key_press = (bus.keycode != 8'h00) && (bus.keycode != prev_key);
    end

    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            ret_state  <= S_SEL;
            lfsr       <= LFSR_SEED;
            prev_key   <= 8'h00;
            enemy_ids  <= '0;
            enemy_idx  <= 2'd0;
            my_cur     <= 2'd0;
            my_hp      <= 8'd0;
            enemy_hp   <= 8'd0;
            move_sel   <= 2'd0;
            result     <= 1'b0;
            end_battle <= 1'b0;
            busy       <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            prev_key   <= bus.keycode;
            end_battle <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.start_battle) begin
                        state <= S_SETUP;
                        busy  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    enemy_ids[0] <= lfsr[2:0];
                    enemy_ids[1] <= lfsr[5:3];
                    enemy_ids[2] <= {lfsr[7:6], lfsr[0]};
                    enemy_idx    <= 2'd0;
                    my_cur       <= 2'd0;
                    move_sel     <= 2'd0;
                    my_hp        <= MAX_HP;
                    enemy_hp     <= MAX_HP;
                    result       <= 1'b0;
                    state        <= S_SEL;
                end
                S_SEL: begin
                    if (key_press) begin
                        if (bus.keycode == KEY_A)          move_sel <= move_sel - 2'd1;
                        else if (bus.keycode == KEY_D)     move_sel <= move_sel + 2'd1;
                        else if (bus.keycode == KEY_ENTER) state    <= S_PHIT;
                    end
                end
                S_PHIT: begin
                    enemy_hp <= (enemy_hp > player_dmg) ? enemy_hp - player_dmg : 8'd0;
                    state    <= S_ECHK;
                end
                S_ECHK: begin
                    if (enemy_hp == 8'd0 && enemy_idx == 2'd2) begin
                        result     <= 1'b1;
                        end_battle <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        // A knockout keeps the initiative with the player.
                        if (enemy_hp == 8'd0) begin
                            enemy_idx <= enemy_idx + 2'd1;
                            enemy_hp  <= MAX_HP;
                            ret_state <= S_SEL;
                        end else begin
                            ret_state <= S_EHIT;
                        end
                        wait_cnt <= WAIT_CYCLES - 25'd1;
                        state    <= S_WAIT;
                    end
                end
                S_EHIT: begin
                    my_hp <= ({1'b0, my_hp} > enemy_dmg) ? my_hp - enemy_dmg[7:0] : 8'd0;
                    state <= S_PCHK;
                end
                S_PCHK: begin
                    if (my_hp == 8'd0 && my_cur == 2'd2) begin
                        result     <= 1'b0;
                        end_battle <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        if (my_hp == 8'd0) begin
                            my_cur <= my_cur + 2'd1;
                            my_hp  <= MAX_HP;
                        end
                        ret_state <= S_SEL;
                        wait_cnt  <= WAIT_CYCLES - 25'd1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) state <= ret_state;
                    else                wait_cnt <= wait_cnt - 25'd1;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.end_battle   = end_battle;
    assign bus.result       = result;
    assign bus.my_cur       = my_cur;
    assign bus.enemy_cur_id = enemy_ids[enemy_idx];
    assign bus.my_hp        = my_hp;
    assign bus.enemy_hp     = enemy_hp;
    assign bus.move_sel     = move_sel;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_battle_engine.sv
// Directed bench for battle_engine: a small spec model tracks HP, indices and
// the LFSR so every expected value is derived here, not read from the DUT.
module tb_battle_engine;
    localparam int WC = 4;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    battle_engine_if bus();

    battle_engine #(
        .MAX_HP(8'd100), .DMG0(8'd20), .DMG1(8'd15), .DMG2(8'd30), .DMG3(8'd10),
        .ENEMY_DMG(8'd12), .WAIT_CYCLES(25'd4), .LFSR_SEED(8'hA5)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_bad = 0;
    int end_pulses = 0;
    logic [7:0] lfsr_m;

    int dmg_tab[4] = '{20, 15, 30, 10};
    int m_my_hp, m_e_hp, m_my_cur, m_e_idx, m_sel, m_result;
    logic [2:0] m_ids[3];

    // Reference LFSR: x^8+x^6+x^5+x^4+1, free-running from the seed.
    always @(posedge Clk) begin
        if (Reset) lfsr_m <= 8'hA5;
        else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    always @(negedge Clk) if (bus.end_battle) end_pulses++;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic tap(input logic [7:0] k);
        bus.keycode = k;
        cyc();
        bus.keycode = 8'h00;
        cyc();
    endtask

    task automatic start_seq();
        logic [7:0] l;
        bus.start_battle = 1'b1;
        cyc();
        bus.start_battle = 1'b0;
        l = lfsr_m;
        check("busy_setup", bus.busy, 1);
        m_ids[0] = l[2:0];
        m_ids[1] = l[5:3];
        m_ids[2] = {l[7:6], l[0]};
        m_my_hp = 100; m_e_hp = 100; m_my_cur = 0; m_e_idx = 0; m_sel = 0;
        cyc();
        check("setup_my_hp", bus.my_hp, 100);
        check("setup_enemy_hp", bus.enemy_hp, 100);
        check("setup_my_cur", bus.my_cur, 0);
        check("setup_enemy_id", bus.enemy_cur_id, m_ids[0]);
        check("setup_move_sel", bus.move_sel, 0);
        check("setup_result", bus.result, 0);
    endtask

    // One ENTER-driven round; leaves the bench in SEL or just after DONE.
    task automatic attack(output bit finished);
        int dmg, edmg;
        logic [7:0] l;
        finished = 1'b0;
        dmg = dmg_tab[m_sel];
        bus.keycode = 8'h28;
        cyc();
        bus.keycode = 8'h00;
        cyc();
        m_e_hp = (m_e_hp > dmg) ? m_e_hp - dmg : 0;
        check("enemy_hp", bus.enemy_hp, m_e_hp);
        cyc();
        if (m_e_hp == 0 && m_e_idx == 2) begin
            check("win_end_pulse", bus.end_battle, 1);
            check("win_result", bus.result, 1);
            finished = 1'b1;
            cyc();
            check("win_end_low", bus.end_battle, 0);
            check("win_idle_busy", bus.busy, 0);
            check("win_result_hold", bus.result, 1);
            return;
        end
        if (m_e_hp == 0) begin
            m_e_idx++;
            m_e_hp = 100;
            check("ko_busy", bus.busy, 1);
            repeat (WC) cyc();
            check("ko_enemy_hp", bus.enemy_hp, 100);
            check("ko_enemy_id", bus.enemy_cur_id, m_ids[m_e_idx]);
            check("ko_no_enemy_turn", bus.my_hp, m_my_hp);
            return;
        end
        repeat (WC) cyc();
        l = lfsr_m;
        edmg = 12 + l[2:0];
        cyc();
        m_my_hp = (m_my_hp > edmg) ? m_my_hp - edmg : 0;
        check("my_hp", bus.my_hp, m_my_hp);
        cyc();
        if (m_my_hp == 0 && m_my_cur == 2) begin
            check("loss_end_pulse", bus.end_battle, 1);
            check("loss_result", bus.result, 0);
            finished = 1'b1;
            cyc();
            check("loss_end_low", bus.end_battle, 0);
            check("loss_idle_busy", bus.busy, 0);
            return;
        end
        if (m_my_hp == 0) begin
            m_my_cur++;
            m_my_hp = 100;
        end
        repeat (WC) cyc();
        check("round_my_cur", bus.my_cur, m_my_cur);
        check("round_my_hp", bus.my_hp, m_my_hp);
    endtask

    initial begin
        bit fin;
        int guard;
        bus.start_battle = 1'b0;
        bus.keycode = 8'h00;
        bus.my_team = {3'd5, 3'd3, 3'd1};
        repeat (3) cyc();
        check("rst_end", bus.end_battle, 0);
        check("rst_result", bus.result, 0);
        check("rst_my_cur", bus.my_cur, 0);
        check("rst_move_sel", bus.move_sel, 0);
        check("rst_my_hp", bus.my_hp, 0);
        check("rst_enemy_hp", bus.enemy_hp, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_enemy_id", bus.enemy_cur_id, 0);
        Reset = 1'b0;
        cyc();

        start_seq();

        // A held key counts once; A/D wrap modulo 4.
        bus.keycode = 8'h07;
        repeat (10) cyc();
        check("hold_d", bus.move_sel, 1);
        bus.keycode = 8'h00;
        cyc();
        tap(8'h07); check("d_2", bus.move_sel, 2);
        tap(8'h07); check("d_3", bus.move_sel, 3);
        tap(8'h07); check("d_wrap_0", bus.move_sel, 0);
        tap(8'h04); check("a_wrap_3", bus.move_sel, 3);
        tap(8'h04); check("a_2", bus.move_sel, 2);
        m_sel = 2;

        attack(fin);
        check("first_hit_range", int'(bus.my_hp >= 8'd81 && bus.my_hp <= 8'd88), 1);

        // start_battle outside IDLE must not restart the battle.
        bus.start_battle = 1'b1;
        cyc();
        bus.start_battle = 1'b0;
        cyc();
        check("sel_start_my_hp", bus.my_hp, m_my_hp);
        check("sel_start_enemy_hp", bus.enemy_hp, m_e_hp);
        check("sel_start_move", bus.move_sel, 2);

        guard = 0;
        while (!fin && guard < 40) begin
            attack(fin);
            guard++;
        end
        check("win_finished", fin, 1);
        check("win_pulses", end_pulses, 1);

        start_seq();
        tap(8'h04);
        check("loss_sel_3", bus.move_sel, 3);
        m_sel = 3;
        fin = 1'b0;
        guard = 0;
        while (!fin && guard < 60) begin
            attack(fin);
            guard++;
        end
        check("loss_finished", fin, 1);
        check("loss_result_hold", bus.result, 0);
        check("loss_pulses", end_pulses, 2);

        // Reset in WAIT aborts without an end_battle pulse.
        start_seq();
        bus.keycode = 8'h28;
        cyc();
        bus.keycode = 8'h00;
        repeat (3) cyc();
        check("pre_rst_busy", bus.busy, 1);
        Reset = 1'b1;
        cyc();
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_my_hp", bus.my_hp, 0);
        check("mid_rst_enemy_hp", bus.enemy_hp, 0);
        check("mid_rst_enemy_id", bus.enemy_cur_id, 0);
        check("mid_rst_result", bus.result, 0);
        check("mid_rst_end", bus.end_battle, 0);
        Reset = 1'b0;
        repeat (WC + 4) cyc();
        check("mid_rst_idle", bus.busy, 0);
        check("mid_rst_pulses", end_pulses, 2);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
